// File: rtl/sdram_resp_pkg.sv
// Shared opcodes, init-state encoding, timing constants and mode-register decode for the SDRAM responder.
package sdram_resp_pkg;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_BST = 3'b110;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam int T_RCD = 2;
    localparam int T_RP  = 2;
    localparam int T_RFC = 7;

    typedef enum logic [2:0] {
        W_PRE  = 3'd0,
        W_REF1 = 3'd1,
        W_REF2 = 3'd2,
        W_MRS  = 3'd3,
        READY  = 3'd4
    } init_state_t;

    function automatic logic mode_bad(input logic [2:0] cl_f, input logic [2:0] bl_f);
        return !((cl_f == 3'd2 || cl_f == 3'd3) && bl_f <= 3'd3);
    endfunction

    // Burst length in words; an illegal mode falls back to single-word bursts.
    function automatic logic [3:0] bl_decode(input logic [2:0] cl_f, input logic [2:0] bl_f);
        if (mode_bad(cl_f, bl_f))
            return 4'd1;
        return 4'd1 << bl_f[1:0];
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Simple-dual-port synchronous RAM holding the responder's data array; registered read, one cycle latency.
module sdram_resp_mem #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdram_cmd_responder.sv
// Device-side SDRAM command responder: init tracking, bank state, burst engine and CAS-latency read pipe.
// Optional timing checks (tRCD/tRP/tRFC) are enabled by defining SDRAM_RESP_TIMING_CHECK_EN.
//
// state  | meaning
// W_PRE  | waiting for PRECHARGE-all
// W_REF1 | waiting for first AUTO REFRESH
// W_REF2 | waiting for second AUTO REFRESH
// W_MRS  | waiting for LOAD MODE
// READY  | init complete, normal operation
module sdram_cmd_responder
    import sdram_resp_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int DQ_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [17:0]     cmd,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            init_done,
    output logic [11:0]     mode_reg,
    output logic            err_cmd
);

    localparam int AW = 2 + ROW_BITS + COL_BITS;

    logic        cs_n;
    logic [2:0]  op;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [2:0]  opc;

    assign {cs_n, op, ba, addr} = cmd;
    assign opc = cs_n ? CMD_NOP : op;

    init_state_t         init_st;
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] open_row [4];

    logic                bst_act, bst_rd, bst_ap;
    logic [1:0]          bst_ba;
    logic [ROW_BITS-1:0] bst_row;
    logic [COL_BITS-1:0] bst_col;
    logic [2:0]          bst_idx;
    logic [3:0]          bst_len;

    logic                v1, v2, oe_q;
    logic [DQ_W-1:0]     d2, rdata;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    logic [2:0] trcd_cnt, trp_cnt, trfc_cnt;
`endif

    logic       init_rej, state_rej, time_rej, blocked, err_now;
    logic       rd_go, wr_go, bst_go, eng_step, issue_rd, issue_wr;
    logic [3:0] len_now;
    logic       cl3;

    assign len_now = bl_decode(mode_reg[6:4], mode_reg[2:0]);
    assign cl3     = !mode_bad(mode_reg[6:4], mode_reg[2:0]) && (mode_reg[6:4] == 3'd3);

    always_comb begin
        init_rej = 1'b0;
        if (init_st != READY && opc != CMD_NOP) begin
            case (init_st)
                W_PRE:          init_rej = !(opc == CMD_PRE && addr[10]);
                W_REF1, W_REF2: init_rej = (opc != CMD_REF);
                W_MRS:          init_rej = (opc != CMD_MRS);
                default:        init_rej = 1'b0;
            endcase
        end

        state_rej = 1'b0;
        case (opc)
            CMD_ACT:          state_rej = bank_open[ba];
            CMD_RD, CMD_WR:   state_rej = !bank_open[ba];
            CMD_REF, CMD_MRS: state_rej = |bank_open;
            default:          state_rej = 1'b0;
        endcase

`ifdef SDRAM_RESP_TIMING_CHECK_EN
        time_rej = (opc != CMD_NOP && trfc_cnt != 3'd0)
                || ((opc == CMD_RD || opc == CMD_WR) && trcd_cnt != 3'd0)
                || (opc == CMD_ACT && trp_cnt != 3'd0);
`else
        time_rej = 1'b0;
`endif

        blocked = init_rej || state_rej || time_rej;
        // An illegal mode is still latched, so it flags an error without blocking.
        err_now = blocked || (opc == CMD_MRS && mode_bad(addr[6:4], addr[2:0]));
        rd_go   = (opc == CMD_RD)  && !blocked;
        wr_go   = (opc == CMD_WR)  && !blocked;
        bst_go  = (opc == CMD_BST) && !blocked;
    end

    // A new accepted READ/WRITE or BURST STOP takes precedence over the running burst.
    assign eng_step = bst_act && !rd_go && !wr_go && !bst_go;
    assign issue_rd = rd_go || (eng_step && bst_rd);
    assign issue_wr = wr_go || (eng_step && !bst_rd);

    logic [1:0]          w_ba;
    logic [ROW_BITS-1:0] w_row;
    logic [COL_BITS-1:0] w_base, w_col, mask;
    logic [2:0]          w_idx;
    logic [3:0]          w_len;

    always_comb begin
        w_ba   = bst_ba;
        w_row  = bst_row;
        w_base = bst_col;
        w_idx  = bst_idx;
        w_len  = bst_len;
        if (rd_go || wr_go) begin
            w_ba   = ba;
            w_row  = open_row[ba];
            w_base = addr[COL_BITS-1:0];
            w_idx  = 3'd0;
            w_len  = len_now;
        end
        mask  = COL_BITS'(w_len - 4'd1);
        w_col = (w_base & ~mask) | ((w_base + COL_BITS'(w_idx)) & mask);
    end

    sdram_resp_mem #(.AW(AW), .DW(DQ_W)) u_mem (
        .clk   (clk),
        .we    (issue_wr),
        .waddr ({w_ba, w_row, w_col}),
        .wdata (dq_in),
        .raddr ({w_ba, w_row, w_col}),
        .rdata (rdata)
    );

    assign dq_oe = oe_q && !wr_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_st   <= W_PRE;
            init_done <= 1'b0;
            mode_reg  <= 12'h000;
            err_cmd   <= 1'b0;
            bank_open <= 4'b0000;
            bst_act   <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            oe_q      <= 1'b0;
            dq_out    <= '0;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
            trcd_cnt  <= 3'd0;
            trp_cnt   <= 3'd0;
            trfc_cnt  <= 3'd0;
`endif
        end else begin
            err_cmd <= err_now;

            if (!blocked) begin
                if (init_st != READY && opc != CMD_NOP) begin
                    case (init_st)
                        W_PRE:   init_st <= W_REF1;
                        W_REF1:  init_st <= W_REF2;
                        W_REF2:  init_st <= W_MRS;
                        W_MRS: begin
                            init_st   <= READY;
                            init_done <= 1'b1;
                        end
                        default: init_st <= init_st;
                    endcase
                end
                case (opc)
                    CMD_ACT: begin
                        bank_open[ba] <= 1'b1;
                        open_row[ba]  <= addr[ROW_BITS-1:0];
                    end
                    CMD_PRE: begin
                        if (addr[10])
                            bank_open <= 4'b0000;
                        else
                            bank_open[ba] <= 1'b0;
                    end
                    CMD_MRS: mode_reg <= addr;
                    default: ;
                endcase
            end

            if (rd_go || wr_go) begin
                bst_rd  <= rd_go;
                bst_ba  <= ba;
                bst_row <= open_row[ba];
                bst_col <= addr[COL_BITS-1:0];
                bst_len <= len_now;
                bst_ap  <= addr[10];
                bst_idx <= 3'd1;
                bst_act <= (len_now != 4'd1);
                if (len_now == 4'd1 && addr[10])
                    bank_open[ba] <= 1'b0;
            end else if (bst_go) begin
                bst_act <= 1'b0;
            end else if (bst_act) begin
                bst_idx <= bst_idx + 3'd1;
                if ({1'b0, bst_idx} == bst_len - 4'd1) begin
                    bst_act <= 1'b0;
                    if (bst_ap)
                        bank_open[bst_ba] <= 1'b0;
                end
            end

            // v1 lines up with rdata; CL=3 inserts one more register stage.
            v1 <= issue_rd;
            v2 <= v1;
            d2 <= rdata;
            if (cl3) begin
                oe_q   <= v2;
                dq_out <= v2 ? d2 : '0;
            end else begin
                oe_q   <= v1;
                dq_out <= v1 ? rdata : '0;
            end
            if (wr_go) begin
                v1     <= 1'b0;
                v2     <= 1'b0;
                oe_q   <= 1'b0;
                dq_out <= '0;
            end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
            if (trcd_cnt != 3'd0) trcd_cnt <= trcd_cnt - 3'd1;
            if (trp_cnt  != 3'd0) trp_cnt  <= trp_cnt  - 3'd1;
            if (trfc_cnt != 3'd0) trfc_cnt <= trfc_cnt - 3'd1;
            if (!blocked) begin
                if (opc == CMD_ACT) trcd_cnt <= 3'(T_RCD - 1);
                if (opc == CMD_PRE) trp_cnt  <= 3'(T_RP - 1);
                if (opc == CMD_REF) trfc_cnt <= 3'(T_RFC - 1);
            end
`endif
        end
    end

endmodule
